rr_priority_arbiter: RTL and testbench
======================================

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 Parameter N, default 4, is the number of requesters; legal range 2..64.
REQ-002 Parameter MODE, default 1, selects the arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter MAX_HOLD, default 0, sets the maximum number of consecutive grant cycles per owner; 0 = unlimited.
REQ-004 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  Reset; synchronous and active-high.
REQ-006 req  input  N  Request vector; bit i high = requester i wants the resource.
REQ-007 any_req  output  1  Combinational OR of all req bits.
REQ-008 gnt  output  N  Registered one-hot grant; all zeros when no grant.
REQ-009 gnt_idx  output  $clog2(N)  Registered binary index of the current owner; valid only while gnt_valid=1.
REQ-010 gnt_valid  output  1  Registered; high while any grant is active.

Function
REQ-011 The block SHALL use two states: IDLE (no owner) and GRANT (one owner held).
REQ-012 In IDLE with any_req=1, the next edge SHALL enter GRANT and register gnt, gnt_idx and gnt_valid=1 for the winner (latency 1 cycle from req to gnt).
REQ-013 In IDLE with any_req=0, the block SHALL stay in IDLE with gnt=0 and gnt_valid=0.
REQ-014 MODE=0: the winner SHALL be the highest-index asserted req bit.
REQ-015 MODE=1: the winner SHALL be the first asserted bit searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
REQ-016 MODE=1: on each grant to index k, ptr SHALL update to (k+1) mod N on the same edge, wrapping from N-1 to 0.
REQ-017 MODE=0: ptr SHALL be unused and held at 0.
REQ-018 In GRANT, the grant SHALL be held unchanged while req[gnt_idx]=1 and the hold limit has not been reached; other req changes SHALL be ignored.
REQ-019 In GRANT, when req[gnt_idx]=0 at an edge, the block SHALL clear gnt and gnt_valid on that edge and return to IDLE.
REQ-020 A hold counter SHALL be cleared on entry to GRANT and increment once per GRANT cycle.
REQ-021 If MAX_HOLD>0 and the owner has held gnt for MAX_HOLD cycles, the next edge SHALL force release to IDLE, regardless of req.
REQ-022 Every release SHALL leave exactly one IDLE cycle (gnt_valid=0) before the next grant; there are no back-to-back grants.
REQ-023 After a forced release in MODE=1, the still-requesting owner SHALL have the lowest priority at the next arbitration.
REQ-024 After a forced release in MODE=0, the still-requesting owner SHALL re-win if it is still the highest index.
REQ-025 gnt SHALL be one-hot or all zeros at all times, and gnt[gnt_idx]=1 whenever gnt_valid=1.
REQ-026 The hold counter width SHALL be $clog2(MAX_HOLD+1), minimum 1 bit, and it SHALL never wrap while in GRANT.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0 and hold counter=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-grant; the first arbitration after reset SHALL occur on the first edge with rst=0 and any_req=1.
REQ-029 any_req SHALL reflect req combinationally, including during reset.

Verification (N=4)
REQ-030 MODE=0: req=4'b0101 held -> gnt=4'b0100 and gnt_idx=2 one cycle later; gnt held while req[2]=1.
REQ-031 MODE=1: req=4'b1111 held, each owner drops its req for one cycle after 2 grant cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 MODE=1: ptr=3 and req=4'b1001 -> owner 3, then ptr wraps to 0; next arbitration with req=4'b1001 -> owner 0.
REQ-033 MAX_HOLD=3, MODE=1: req=4'b0011 held constantly -> owner 0 for exactly 3 cycles, 1 idle cycle, then owner 1 for 3 cycles.
REQ-034 rst=1 asserted during GRANT with owner 2 -> the next edge shows gnt=0, gnt_valid=0; after rst=0 with req=4'b1111 in MODE=1 -> owner 0.
REQ-035 req=4'b0000 throughout -> any_req=0, gnt_valid=0 and gnt=0 on every cycle; one-hot check (REQ-025) runs as an assertion in every test.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//
// Grants a shared resource to one of N requesters. The policy is either
// fixed priority or round-robin, and an optional limit caps how many
// consecutive cycles one owner may hold the grant. The grant outputs are
// registered, so a winner sees its grant one cycle after it requests.
// Every release is followed by one idle cycle before the next grant.
//
// Parameters
//   N        number of requesters (2..64)
//   MODE     0 = fixed priority (highest index wins), 1 = round-robin
//   MAX_HOLD maximum consecutive grant cycles per owner, 0 = unlimited
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   req        request vector, bit i = requester i wants the resource
//   any_req    combinational OR of req, also valid during reset
//   gnt        registered one-hot grant, all zeros when idle
//   gnt_idx    registered binary index of the owner (valid with gnt_valid)
//   gnt_valid  registered, high while a grant is active

module rr_priority_arbiter #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic                 any_req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // The release fires on the edge that closes the MAX_HOLD-th grant
    // cycle; the counter reads MAX_HOLD-1 during that cycle.
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [HW-1:0] HOLD_SAT  = '1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW:0]   N_WIDE    = (IW + 1)'(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [N-1:0]    gnt_d;
    logic [IW-1:0]   idx_d;
    logic            valid_d;

    logic [IW-1:0]   win_idx;
    logic [N-1:0]    rotated;
    logic [IW:0]     pos;

    assign any_req = |req;

    // Winner selection. Round-robin rotates req so that bit 0 of the
    // rotated vector is requester ptr, finds the first set bit, then maps
    // that offset back to a real index modulo N (N need not be a power of 2).
    always_comb begin
        win_idx = '0;
        rotated = '0;
        pos     = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_idx = IW'(i);
                end
            end
        end else begin
            rotated = N'({req, req} >> ptr);
            for (int j = N - 1; j >= 0; j--) begin
                if (rotated[j]) begin
                    pos = {1'b0, ptr} + (IW + 1)'(j);
                end
            end
            if (pos >= N_WIDE) begin
                pos = pos - N_WIDE;
            end
            win_idx = pos[IW-1:0];
        end
    end

    // Next-state and next-output logic. A grant is taken only from IDLE,
    // which is what guarantees the idle cycle between owners. The hold
    // counter saturates so it cannot wrap when the hold is unlimited.
    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        valid_d = gnt_valid;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    if (MODE != 0) begin
                        ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    end
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || ((MAX_HOLD > 0) && (hold_cnt == HOLD_LAST))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers; reset wins over everything, even mid-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter
//
// Directed bench for rr_priority_arbiter with N=4. Four instances cover
// fixed priority, round-robin, round-robin with a 3-cycle hold limit and
// fixed priority with a 2-cycle hold limit. Expected grants are written
// out by hand. The grant invariants are checked on every falling edge.

module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0, req1, req2, req3;
    logic       any_req0, any_req1, any_req2, any_req3;
    logic [3:0] gnt0, gnt1, gnt2, gnt3;
    logic [1:0] idx0, idx1, idx2, idx3;
    logic       valid0, valid1, valid2, valid3;

    int checks = 0;
    int errors = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fixed (
        .clk(clk), .rst(rst), .req(req0), .any_req(any_req0),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(valid0)
    );

    rr_priority_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .req(req1), .any_req(any_req1),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(valid1)
    );

    rr_priority_arbiter #(.N(4), .MODE(1), .MAX_HOLD(3)) u_rr_hold (
        .clk(clk), .rst(rst), .req(req2), .any_req(any_req2),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(valid2)
    );

    rr_priority_arbiter #(.N(4), .MODE(0), .MAX_HOLD(2)) u_fixed_hold (
        .clk(clk), .rst(rst), .req(req3), .any_req(any_req3),
        .gnt(gnt3), .gnt_idx(idx3), .gnt_valid(valid3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [3:0] r);
        case (sel)
            0:       req0 = r;
            1:       req1 = r;
            2:       req2 = r;
            default: req3 = r;
        endcase
        step();
    endtask

    task automatic checkGrant(input string tag, input int sel,
                              input logic [3:0] exp_gnt, input logic [1:0] exp_idx);
        logic [3:0] g;
        logic [1:0] ix;
        logic       v;
        case (sel)
            0:       begin g = gnt0; ix = idx0; v = valid0; end
            1:       begin g = gnt1; ix = idx1; v = valid1; end
            2:       begin g = gnt2; ix = idx2; v = valid2; end
            default: begin g = gnt3; ix = idx3; v = valid3; end
        endcase
        checkOutput({tag, "_gnt"}, g, exp_gnt);
        checkOutput({tag, "_valid"}, v, |exp_gnt);
        if (exp_gnt != 4'b0000) begin
            checkOutput({tag, "_idx"}, ix, exp_idx);
        end
    endtask

    task automatic checkInvariant(input string tag, input logic [3:0] g,
                                  input logic [1:0] ix, input logic v);
        checkOutput({tag, "_onehot0"}, $onehot0(g), 1);
        checkOutput({tag, "_valid_eq_or"}, v, |g);
        if (v) begin
            checkOutput({tag, "_gnt_at_idx"}, g[ix], 1);
        end
    endtask

    task automatic resetAll();
        rst  = 1'b1;
        req0 = '0;
        req1 = '0;
        req2 = '0;
        req3 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Grant invariants on every instance, sampled away from the rising edge.
    always @(negedge clk) begin
        if (inv_on) begin
            checkInvariant("inv_fixed", gnt0, idx0, valid0);
            checkInvariant("inv_rr", gnt1, idx1, valid1);
            checkInvariant("inv_rr_hold", gnt2, idx2, valid2);
            checkInvariant("inv_fixed_hold", gnt3, idx3, valid3);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int         o;
        logic [3:0] oh;

        rst  = 1'b1;
        req0 = '0;
        req1 = '0;
        req2 = '0;
        req3 = '0;
        step();
        inv_on = 1'b1;
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        checkGrant("rst_rr", 1, 4'b0000, 2'd0);
        checkOutput("rst_rr_idx", idx1, 0);
        checkGrant("rst_fixed", 0, 4'b0000, 2'd0);

        $display("[TB] no requests");
        for (int n = 0; n < 4; n++) begin
            step();
            checkOutput("idle_anyreq", any_req1, 0);
            checkGrant("idle_rr", 1, 4'b0000, 2'd0);
            checkGrant("idle_fixed", 0, 4'b0000, 2'd0);
        end

        $display("[TB] fixed priority");
        req0 = 4'b0101;
        #1;
        checkOutput("fx_anyreq", any_req0, 1);
        step();
        checkGrant("fx_win", 0, 4'b0100, 2'd2);
        for (int n = 0; n < 3; n++) begin
            step();
            checkGrant("fx_hold", 0, 4'b0100, 2'd2);
        end
        applyStimulus(0, 4'b0111);
        checkGrant("fx_ignore", 0, 4'b0100, 2'd2);
        applyStimulus(0, 4'b0011);
        checkGrant("fx_release", 0, 4'b0000, 2'd0);
        step();
        checkGrant("fx_rearb", 0, 4'b0010, 2'd1);
        applyStimulus(0, 4'b0000);
        checkGrant("fx_drop", 0, 4'b0000, 2'd0);

        $display("[TB] round-robin order");
        resetAll();
        req1 = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            o  = n % 4;
            oh = 4'b0001 << o;
            step();
            checkGrant("rr_order", 1, oh, 2'(o));
            step();
            checkGrant("rr_order_hold", 1, oh, 2'(o));
            req1 = 4'b1111 & ~oh;
            step();
            checkGrant("rr_order_idle", 1, 4'b0000, 2'd0);
            req1 = 4'b1111;
        end
        step();
        checkGrant("rr_nolimit_win", 1, 4'b0010, 2'd1);
        for (int n = 0; n < 12; n++) begin
            step();
            checkGrant("rr_nolimit_hold", 1, 4'b0010, 2'd1);
        end
        applyStimulus(1, 4'b0000);
        checkGrant("rr_nolimit_rel", 1, 4'b0000, 2'd0);

        $display("[TB] round-robin pointer wrap");
        resetAll();
        applyStimulus(1, 4'b0100);
        checkGrant("wrap_set", 1, 4'b0100, 2'd2);
        applyStimulus(1, 4'b0000);
        checkGrant("wrap_idle0", 1, 4'b0000, 2'd0);
        applyStimulus(1, 4'b1001);
        checkGrant("wrap_own3", 1, 4'b1000, 2'd3);
        applyStimulus(1, 4'b0000);
        checkGrant("wrap_idle1", 1, 4'b0000, 2'd0);
        applyStimulus(1, 4'b1001);
        checkGrant("wrap_own0", 1, 4'b0001, 2'd0);

        $display("[TB] reset during grant");
        applyStimulus(1, 4'b0000);
        checkGrant("mid_idle", 1, 4'b0000, 2'd0);
        applyStimulus(1, 4'b0100);
        checkGrant("mid_own2", 1, 4'b0100, 2'd2);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_anyreq", any_req1, 1);
        step();
        checkGrant("mid_rst", 1, 4'b0000, 2'd0);
        checkOutput("mid_rst_idx", idx1, 0);
        step();
        checkGrant("mid_rst_held", 1, 4'b0000, 2'd0);
        rst = 1'b0;
        applyStimulus(1, 4'b1111);
        checkGrant("mid_after", 1, 4'b0001, 2'd0);
        req1 = 4'b0000;

        $display("[TB] round-robin hold limit");
        resetAll();
        req2 = 4'b0011;
        for (int n = 0; n < 3; n++) begin
            step();
            checkGrant("lim_own0", 2, 4'b0001, 2'd0);
        end
        step();
        checkGrant("lim_idle0", 2, 4'b0000, 2'd0);
        for (int n = 0; n < 3; n++) begin
            step();
            checkGrant("lim_own1", 2, 4'b0010, 2'd1);
        end
        step();
        checkGrant("lim_idle1", 2, 4'b0000, 2'd0);
        step();
        checkGrant("lim_back0", 2, 4'b0001, 2'd0);
        applyStimulus(2, 4'b0000);
        checkGrant("lim_drop", 2, 4'b0000, 2'd0);

        $display("[TB] fixed priority hold limit");
        resetAll();
        req3 = 4'b0101;
        for (int n = 0; n < 2; n++) begin
            step();
            checkGrant("fxl_own2", 3, 4'b0100, 2'd2);
        end
        step();
        checkGrant("fxl_idle", 3, 4'b0000, 2'd0);
        step();
        checkGrant("fxl_rewin", 3, 4'b0100, 2'd2);
        applyStimulus(3, 4'b0000);
        checkGrant("fxl_drop", 3, 4'b0000, 2'd0);

        step();
        inv_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
